mem_backing_store: RTL and testbench

- Main-memory model and controller that sits directly downstream of the L1 data cache and serves its line fills and line write-backs.
- Accepts one request at a time over the cache–memory handshake (VALID/LOAD/STORE → ACK_ADDR, then per-word READY/ACK_DATA beats).
- Applies a fixed, parameterised access latency and transfers a full cache line of LINE_WORDS words per request.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_array.sv | 28 ++
 rtl/mem_backing_store.sv | 149 ++++++++++++++
 tb/tb_mem_backing_store.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and address helpers for the main-memory backing store.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD_BURST,
        STORE_BURST,
        DONE
    } state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } op_t;

    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    // Byte address to word index, wrapped to the array depth (a power of two).
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned depth_words);
        return (byte_addr >> 2) & (depth_words - 1);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] widx,
                                              input int unsigned line_words);
        return widx & ~(line_words - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-wide storage array: synchronous write, combinational read, no reset so
// contents survive a controller reset.
module mem_array
    import mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 4096,
    parameter  int DATA_W      = 32,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_backing_store.sv
// Main-memory controller serving L1 line fills and write-backs with a fixed latency.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range requests return BAD_DATA and drop stores.
module mem_backing_store
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LINE_WORDS  = 4,
    parameter int LATENCY     = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ack_data,
    output logic              ack_addr,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int LW = $clog2(LINE_WORDS);
    localparam int BW = (LW > 0) ? LW : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);

    state_t            state;
    state_t            state_n;
    op_t               op_q;
    logic [AW-1:0]     base_q;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     beat_q;
    logic [CW-1:0]     cnt_q;
    logic              accept;
    logic              beat_hs;
    logic              last_hs;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_data;

    assign accept   = (state == IDLE) && valid && (load ^ store);
    assign beat_hs  = ((state == LOAD_BURST) || (state == STORE_BURST)) && ack_data;
    assign last_hs  = beat_hs && (beat_q == LAST_BEAT);
    assign mem_addr = base_q + AW'(beat_q);

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob_q;
    logic oob_now;

    assign oob_now = (32'(addr) >> (AW + 2)) != 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else if (accept) begin
            oob_q <= oob_now;
            if (oob_now) begin
                $error("mem_backing_store: out-of-range request at address %h", addr);
            end
        end
    end

    assign mem_we    = (state == STORE_BURST) && ack_data && !oob_q;
    assign load_data = oob_q ? DATA_W'(BAD_DATA) : mem_rdata;
`else
    assign mem_we    = (state == STORE_BURST) && ack_data;
    assign load_data = mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        if (accept) state_n = WAIT;
            WAIT:        if (cnt_q == '0) state_n = (op_q == OP_STORE) ? STORE_BURST : LOAD_BURST;
            LOAD_BURST,
            STORE_BURST: if (last_hs) state_n = DONE;
            DONE:        state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    // ack_addr is the first WAIT cycle, recognisable by the untouched counter.
    always_comb begin
        ack_addr = 1'b0;
        ready    = 1'b0;
        rdata    = '0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            WAIT:        ack_addr = (cnt_q == CNT_INIT);
            LOAD_BURST: begin
                ready = 1'b1;
                rdata = load_data;
            end
            STORE_BURST: ready = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            op_q   <= OP_LOAD;
            beat_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            base_q <= AW'(line_base(word_index(32'(addr), DEPTH_WORDS), LINE_WORDS));
            op_q   <= store ? OP_STORE : OP_LOAD;
            cnt_q  <= CNT_INIT;
            beat_q <= '0;
        end else begin
            if ((state == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (beat_hs) begin
                beat_q <= beat_q + BW'(1);
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_addr),
        .wdata(wdata),
        .raddr(mem_addr),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_backing_store.sv
// Self-checking bench for mem_backing_store: a shadow memory feeds a queue of
// expected load beats that are popped as the DUT hands them out.
module tb_mem_backing_store;
    import mem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LINE  = 4;
    localparam int LAT   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack_data;
    logic        ack_addr;
    logic        ready;
    logic [31:0] rdata;
    logic        done;
    logic        busy;

    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [LINE];
    logic [31:0] expq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_backing_store #(
        .DEPTH_WORDS(DEPTH),
        .LINE_WORDS (LINE),
        .LATENCY    (LAT),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .load    (load),
        .store   (store),
        .addr    (addr),
        .wdata   (wdata),
        .ack_data(ack_data),
        .ack_addr(ack_addr),
        .ready   (ready),
        .rdata   (rdata),
        .done    (done),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wbuf(input logic [31:0] start);
        for (int i = 0; i < LINE; i++) wbuf[i] = start + 32'(i);
    endtask

    // One full request. Cycle c=1 is the cycle after the accepting edge T0.
    task automatic run_txn(input bit is_store, input logic [31:0] a, input int stall_beat,
                           input int stall_len, input int abort_beat, input bit poke_wait,
                           input bit check_timing);
        int base, beat, stalled, c, first_ready;
        bit hs;
        logic [31:0] exp_word;
        bit oob;
        base = int'(((a >> 2) & 32'(DEPTH - 1)) & ~32'(LINE - 1));
        oob  = (a >> 14) != 32'd0;
        if (!is_store) begin
            for (int i = 0; i < LINE; i++) begin
`ifdef MEM_BOUNDS_CHECK_EN
                expq.push_back(oob ? BAD_DATA : model[base + i]);
`else
                expq.push_back(model[base + i]);
`endif
            end
        end
        valid = 1'b1; load = !is_store; store = is_store; addr = a;
        tick();
        c = 1;
        checks++;
        if ({ack_addr, busy} !== 2'b11)
            begin errors++; $display("[TB] FAIL ack_addr: got ack/busy %b expected 11", {ack_addr, busy}); end
        if (poke_wait) begin
            load = 1'b0; store = 1'b1; addr = 32'h0000_0800;
        end else begin
            valid = 1'b0; load = 1'b0; store = 1'b0;
        end
        beat = 0; stalled = 0; first_ready = -1;
        while (beat < LINE) begin
            hs = 1'b0;
            if (c > 100) begin
                errors++;
                $display("[TB] FAIL timeout: got beat %0d expected %0d beats", beat, LINE);
                valid = 1'b0; ack_data = 1'b0;
                return;
            end
            if (ready === 1'b1) begin
                valid = 1'b0; load = 1'b0; store = 1'b0;
                if (first_ready < 0) first_ready = c;
                if (beat == abort_beat) begin
                    ack_data = 1'b0;
                    rst = 1'b1;
                    #1;
                    checks++;
                    if ({ack_addr, ready, done, busy} !== 4'b0000 || rdata !== 32'd0)
                        begin errors++; $display("[TB] FAIL async_reset: got outputs %b rdata %h expected 0000 0", {ack_addr, ready, done, busy}, rdata); end
                    tick();
                    rst = 1'b0;
                    tick();
                    return;
                end
                hs = !(beat == stall_beat && stalled < stall_len);
                if (!hs) stalled++;
                ack_data = hs;
                if (is_store) begin
                    wdata = wbuf[beat];
                end else begin
                    exp_word = (expq.size() > 0) ? expq[0] : 32'hxxxx_xxxx;
                    checks++;
                    if (expq.size() == 0 || rdata !== exp_word)
                        begin errors++; $display("[TB] FAIL load_beat%0d: got %h expected %h", beat, rdata, exp_word); end
                    if (hs && expq.size() > 0) void'(expq.pop_front());
                end
            end else begin
                ack_data = 1'b0;
            end
            tick();
            c++;
            if (hs) begin
`ifdef MEM_BOUNDS_CHECK_EN
                if (is_store && !oob) model[base + beat] = wbuf[beat];
`else
                if (is_store) model[base + beat] = wbuf[beat];
`endif
                beat++;
            end
        end
        ack_data = 1'b0;
        checks++;
        if ({done, ready} !== 2'b10)
            begin errors++; $display("[TB] FAIL done_pulse: got done/ready %b expected 10", {done, ready}); end
        if (check_timing) begin
            checks++;
            if (first_ready != LAT + 1)
                begin errors++; $display("[TB] FAIL first_ready: got cycle %0d expected %0d", first_ready, LAT + 1); end
            checks++;
            if (c != LAT + LINE + 1 + stall_len)
                begin errors++; $display("[TB] FAIL done_cycle: got cycle %0d expected %0d", c, LAT + LINE + 1 + stall_len); end
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00)
            begin errors++; $display("[TB] FAIL back_idle: got done/busy %b expected 00", {done, busy}); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (ack_addr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", ack_addr); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_latency();
        $display("[TB] load latency and beat order");
        set_wbuf(32'd1);
        run_txn(1'b1, 32'h0000_0100, -1, 0, -1, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0104, -1, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_store_load();
        $display("[TB] store then load");
        set_wbuf(32'hA0);
        run_txn(1'b1, 32'h0000_0200, -1, 0, -1, 1'b0, 1'b1);
        run_txn(1'b0, 32'h0000_0200, -1, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        $display("[TB] load with stalled beat");
        run_txn(1'b0, 32'h0000_0104, 1, 3, -1, 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        $display("[TB] malformed requests");
        for (int p = 0; p < 2; p++) begin
            valid = 1'b1; load = p[0]; store = p[0]; addr = 32'h0000_0100;
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if ({ack_addr, busy} !== 2'b00)
                    begin errors++; $display("[TB] FAIL illegal_req: got ack/busy %b expected 00", {ack_addr, busy}); end
            end
        end
        valid = 1'b0; load = 1'b0; store = 1'b0;
        tick();
    endtask

    task automatic test_valid_during_wait();
        $display("[TB] valid held during wait");
        run_txn(1'b0, 32'h0000_0200, -1, 0, -1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_store();
        $display("[TB] reset during store burst");
        set_wbuf(32'h11);
        run_txn(1'b1, 32'h0000_0300, -1, 0, -1, 1'b0, 1'b0);
        set_wbuf(32'hB0);
        run_txn(1'b1, 32'h0000_0300, -1, 0, 2, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0308, -1, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        $display("[TB] back-to-back requests");
        set_wbuf(32'hC0);
        run_txn(1'b1, 32'h0000_0400, -1, 0, -1, 1'b0, 1'b1);
        run_txn(1'b0, 32'h0000_040C, -1, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        $display("[TB] high address bits");
        set_wbuf(32'h55);
        run_txn(1'b1, 32'h0000_0000, -1, 0, -1, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0001_0000, -1, 0, -1, 1'b0, 1'b1);
    endtask

    initial begin
        valid = 1'b0; load = 1'b0; store = 1'b0;
        addr = 32'd0; wdata = 32'd0; ack_data = 1'b0;
        test_reset();
        test_load_latency();
        test_store_load();
        test_stall();
        test_illegal();
        test_valid_during_wait();
        test_reset_mid_store();
        test_back_to_back();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
